// File: rtl/code_entry_pkg.sv
// Shared types and key-code constants for the safe combination sequencer.
package code_entry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_PROG,
        ST_FAIL,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] KEY_CLR  = 4'hA;
    localparam logic [3:0] KEY_ENT  = 4'hB;
    localparam logic [3:0] KEY_PROG = 4'hC;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/code_entry_sequencer_if.sv
// Key-event handshake between the keypad scanner (master) and the sequencer (slave).
interface code_entry_sequencer_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );

endinterface

// File: rtl/code_entry_sequencer_state_timer.sv
// Free-running cycle counter with synchronous clear and a terminal compare
// against the limit of whichever state is currently timed.
module state_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + TIMER_W'(1);
        end
    end

    assign expired = (count_reg == (limit - TIMER_W'(1)));

endmodule

// File: rtl/code_entry_sequencer.sv
// Safe combination entry FSM: buffers keypad digits, checks them against the
// stored code, drives lock/LED/lockout outputs and supports re-programming.
module code_entry_sequencer
    import code_entry_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [23:0] DEFAULT_CODE   = 24'h001234,
    parameter int          TIMER_W        = 24,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter int          HOLD_CYCLES    = 500000,
    parameter int          LOCKOUT_CYCLES = 8000000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    code_entry_sequencer_if.slave   key_if,
    output logic                    unlock,
    output logic                    green,
    output logic                    blue,
    output logic                    lockout,
    output logic [1:0]              fail_cnt,
    output logic [2:0]              digit_cnt
);

    localparam logic [2:0]         LEN_CNT     = 3'(CODE_LEN);
    localparam logic [1:0]         FAIL_LIMIT  = 2'(MAX_FAILS);
    localparam logic [TIMER_W-1:0] TIMEOUT_LIM = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LIM    = TIMER_W'(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] LOCKOUT_LIM = TIMER_W'(LOCKOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [2:0]  digit_cnt_reg, digit_cnt_next;
    logic [1:0]  fail_cnt_reg, fail_cnt_next;
    logic        key_ready_reg;
    logic        unlock_reg, green_reg, blue_reg, lockout_reg;

    logic        key_accept;
    logic        key_digit;
    logic        buf_wr;
    logic        buf_clear;
    logic        code_commit;
    logic        code_match;
    logic [CODE_LEN-1:0] slot_match;

    logic               timer_clear;
    logic               timer_expired;
    logic [TIMER_W-1:0] timer_limit;

    assign key_accept = key_if.key_valid && key_ready_reg;
    assign key_digit  = is_digit(key_if.key_code);

    // Per-slot digit buffer and code register; slot 0 is the first digit typed.
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : gen_slot
            logic [3:0] digit_reg;
            logic [3:0] code_reg;

            always_ff @(posedge clk) begin
                if (rst || buf_clear) begin
                    digit_reg <= 4'd0;
                end else if (buf_wr && (digit_cnt_reg == 3'(gi))) begin
                    digit_reg <= key_if.key_code;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    code_reg <= DEFAULT_CODE[(CODE_LEN-1-gi)*4 +: 4];
                end else if (code_commit) begin
                    code_reg <= digit_reg;
                end
            end

            assign slot_match[gi] = (digit_reg == code_reg);
        end
    endgenerate

    assign code_match = (digit_cnt_reg == LEN_CNT) && (&slot_match);

    always_comb begin
        timer_limit = TIMEOUT_LIM;
        case (state_reg)
            ST_FAIL:    timer_limit = HOLD_LIM;
            ST_LOCKOUT: timer_limit = LOCKOUT_LIM;
            default:    timer_limit = TIMEOUT_LIM;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        digit_cnt_next = digit_cnt_reg;
        fail_cnt_next  = fail_cnt_reg;
        buf_wr         = 1'b0;
        buf_clear      = 1'b0;
        code_commit    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (key_accept && key_digit) begin
                    buf_wr         = 1'b1;
                    digit_cnt_next = 3'd1;
                    state_next     = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                if (key_accept) begin
                    if (key_digit) begin
                        if (digit_cnt_reg < LEN_CNT) begin
                            buf_wr         = 1'b1;
                            digit_cnt_next = digit_cnt_reg + 3'd1;
                        end
                    end else if (key_if.key_code == KEY_CLR) begin
                        buf_clear      = 1'b1;
                        digit_cnt_next = 3'd0;
                        state_next     = ST_IDLE;
                    end else if (key_if.key_code == KEY_ENT) begin
                        state_next = ST_CHECK;
                    end
                end else if (timer_expired) begin
                    buf_clear      = 1'b1;
                    digit_cnt_next = 3'd0;
                    state_next     = ST_IDLE;
                end
            end

            ST_CHECK: begin
                buf_clear      = 1'b1;
                digit_cnt_next = 3'd0;
                if (code_match) begin
                    fail_cnt_next = 2'd0;
                    state_next    = ST_OPEN;
                end else begin
                    fail_cnt_next = fail_cnt_reg + 2'd1;
                    state_next    = ((fail_cnt_reg + 2'd1) == FAIL_LIMIT) ? ST_LOCKOUT : ST_FAIL;
                end
            end

            ST_OPEN: begin
                if (key_accept) begin
                    if (key_if.key_code == KEY_ENT) begin
                        state_next = ST_IDLE;
                    end else if (key_if.key_code == KEY_PROG) begin
                        buf_clear      = 1'b1;
                        digit_cnt_next = 3'd0;
                        state_next     = ST_PROG;
                    end
                end else if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end

            ST_PROG: begin
                if (key_accept) begin
                    if (key_digit) begin
                        if (digit_cnt_reg < LEN_CNT) begin
                            buf_wr         = 1'b1;
                            digit_cnt_next = digit_cnt_reg + 3'd1;
                        end
                    end else if (key_if.key_code == KEY_ENT) begin
                        code_commit    = (digit_cnt_reg == LEN_CNT);
                        buf_clear      = 1'b1;
                        digit_cnt_next = 3'd0;
                        state_next     = ST_OPEN;
                    end else if (key_if.key_code == KEY_CLR) begin
                        buf_clear      = 1'b1;
                        digit_cnt_next = 3'd0;
                        state_next     = ST_OPEN;
                    end
                end else if (timer_expired) begin
                    buf_clear      = 1'b1;
                    digit_cnt_next = 3'd0;
                    state_next     = ST_IDLE;
                end
            end

            ST_FAIL: begin
                if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end

            ST_LOCKOUT: begin
                if (timer_expired) begin
                    fail_cnt_next = 2'd0;
                    state_next    = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Keys swallowed in FAIL/LOCKOUT must not stretch the penalty, so only
    // the idle-timeout states restart the timer on an accepted key.
    assign timer_clear = (state_next != state_reg) ||
                         (key_accept && (state_reg != ST_FAIL) && (state_reg != ST_LOCKOUT));

    state_timer #(
        .TIMER_W (TIMER_W)
    ) u_state_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            digit_cnt_reg <= 3'd0;
            fail_cnt_reg  <= 2'd0;
            key_ready_reg <= 1'b1;
            unlock_reg    <= 1'b0;
            green_reg     <= 1'b0;
            blue_reg      <= 1'b0;
            lockout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_cnt_reg <= digit_cnt_next;
            fail_cnt_reg  <= fail_cnt_next;
            key_ready_reg <= (state_next != ST_CHECK);
            unlock_reg    <= (state_next == ST_OPEN) || (state_next == ST_PROG);
            green_reg     <= (state_next == ST_OPEN);
            blue_reg      <= (state_next == ST_FAIL) || (state_next == ST_LOCKOUT) ||
                             (state_next == ST_PROG);
            lockout_reg   <= (state_next == ST_LOCKOUT);
        end
    end

    assign key_if.key_ready = key_ready_reg;
    assign unlock           = unlock_reg;
    assign green            = green_reg;
    assign blue             = blue_reg;
    assign lockout          = lockout_reg;
    assign fail_cnt         = fail_cnt_reg;
    assign digit_cnt        = digit_cnt_reg;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Directed bench for code_entry_sequencer with short timer limits.
module tb_code_entry_sequencer;
    import code_entry_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       unlock, green, blue, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    code_entry_sequencer_if kif ();

    code_entry_sequencer #(
        .TIMEOUT_CYCLES (20),
        .HOLD_CYCLES    (8),
        .LOCKOUT_CYCLES (32),
        .MAX_FAILS      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_if    (kif),
        .unlock    (unlock),
        .green     (green),
        .blue      (blue),
        .lockout   (lockout),
        .fail_cnt  (fail_cnt),
        .digit_cnt (digit_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send_key(input logic [3:0] k);
        int waited = 0;
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_code  = k;
        while (kif.key_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            check_val("key_ready_wait", kif.key_ready, 1);
        end else begin
            @(posedge clk);
        end
        #1 kif.key_valid = 1'b0;
        $display("key %h sent", k);
    endtask

    task automatic send_digits(input logic [23:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_key(code[i*4 +: 4]);
        end
    endtask

    // Call right after ENT is accepted on a code that should open.
    task automatic expect_open(input string tag);
        @(negedge clk);
        check_val({tag, "_check_ready"}, kif.key_ready, 0);
        @(negedge clk);
        check_val({tag, "_unlock"}, unlock, 1);
        check_val({tag, "_green"}, green, 1);
        check_val({tag, "_fail_cnt"}, fail_cnt, 0);
    endtask

    // Call right after ENT is accepted on a code that should fail (not lockout).
    task automatic expect_fail(input string tag, input logic [1:0] exp_fails);
        @(negedge clk);
        check_val({tag, "_check_ready"}, kif.key_ready, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val({tag, "_blue_hold"}, blue, 1);
            if (i == 0) begin
                check_val({tag, "_fail_cnt"}, fail_cnt, exp_fails);
                check_val({tag, "_unlock"}, unlock, 0);
            end
        end
        @(negedge clk);
        check_val({tag, "_blue_end"}, blue, 0);
    endtask

    task automatic relock(input string tag);
        send_key(KEY_ENT);
        @(negedge clk);
        check_val({tag, "_unlock_off"}, unlock, 0);
        check_val({tag, "_green_off"}, green, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_val("rst_key_ready", kif.key_ready, 1);
        check_val("rst_unlock", unlock, 0);
        check_val("rst_blue", blue, 0);
        check_val("rst_lockout", lockout, 0);
        check_val("rst_digit_cnt", digit_cnt, 0);

        // Correct code, then relock.
        send_digits(24'h1234, 4);
        @(negedge clk);
        check_val("entry_digit_cnt", digit_cnt, 4);
        send_key(KEY_ENT);
        expect_open("good");
        relock("good");

        // Three wrong codes: two FAILs then LOCKOUT.
        send_digits(24'h1235, 4);
        send_key(KEY_ENT);
        expect_fail("wrong1", 2'd1);
        send_digits(24'h1235, 4);
        send_key(KEY_ENT);
        expect_fail("wrong2", 2'd2);
        send_digits(24'h1235, 4);
        send_key(KEY_ENT);
        @(negedge clk);
        check_val("wrong3_check_ready", kif.key_ready, 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_val("lockout_active", lockout, 1);
            if (i == 4) begin
                kif.key_valid = 1'b1;
                kif.key_code  = 4'h1;
            end
            if (i == 6) kif.key_valid = 1'b0;
            if (i == 10) check_val("lockout_digit_cnt", digit_cnt, 0);
        end
        @(negedge clk);
        check_val("lockout_end", lockout, 0);
        check_val("lockout_fail_clr", fail_cnt, 0);
        check_val("lockout_blue_off", blue, 0);

        // Short code fails.
        send_digits(24'h123, 3);
        send_key(KEY_ENT);
        expect_fail("short", 2'd1);

        // Idle timeout in ENTRY.
        send_digits(24'h12, 2);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) check_val("timeout_last_entry", digit_cnt, 2);
        end
        @(negedge clk);
        check_val("timeout_digit_cnt", digit_cnt, 0);
        check_val("timeout_fail_cnt", fail_cnt, 1);

        // Key on the expiry cycle wins over the timeout.
        send_digits(24'h12, 2);
        repeat (19) @(negedge clk);
        send_key(4'h3);
        @(negedge clk);
        check_val("expiry_key_kept", digit_cnt, 3);
        send_key(KEY_CLR);
        @(negedge clk);
        check_val("clr_digit_cnt", digit_cnt, 0);

        // Overflow digit is dropped.
        send_digits(24'h12349, 5);
        @(negedge clk);
        check_val("overflow_sat", digit_cnt, 4);
        send_key(KEY_ENT);
        expect_open("overflow");

        // Reprogram to 9876.
        send_key(KEY_PROG);
        @(negedge clk);
        check_val("prog_blue", blue, 1);
        check_val("prog_unlock", unlock, 1);
        send_digits(24'h9876, 4);
        @(negedge clk);
        check_val("prog_digit_cnt", digit_cnt, 4);
        send_key(KEY_ENT);
        @(negedge clk);
        check_val("commit_green", green, 1);
        check_val("commit_blue", blue, 0);
        relock("prog");

        send_digits(24'h1234, 4);
        send_key(KEY_ENT);
        expect_fail("oldcode", 2'd1);
        send_digits(24'h9876, 4);
        send_key(KEY_ENT);
        expect_open("newcode");
        relock("newcode");

        // Key held through CHECK is taken only once ready returns.
        send_digits(24'h9876, 4);
        @(negedge clk);
        kif.key_valid = 1'b1;
        kif.key_code  = KEY_ENT;
        @(posedge clk);
        #1 kif.key_code = KEY_PROG;
        @(negedge clk);
        check_val("hold_check_ready", kif.key_ready, 0);
        @(negedge clk);
        check_val("hold_open_ready", kif.key_ready, 1);
        check_val("hold_open_green", green, 1);
        @(posedge clk);
        #1 kif.key_valid = 1'b0;
        @(negedge clk);
        check_val("hold_prog_blue", blue, 1);
        check_val("hold_prog_green", green, 0);

        // Reset mid-PROG.
        send_key(4'h5);
        @(negedge clk);
        check_val("midprog_digit_cnt", digit_cnt, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_unlock", unlock, 0);
        check_val("midrst_blue", blue, 0);
        check_val("midrst_digit_cnt", digit_cnt, 0);
        check_val("midrst_key_ready", kif.key_ready, 1);
        rst = 1'b0;

        // Default code restored.
        send_digits(24'h1234, 4);
        send_key(KEY_ENT);
        expect_open("restored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
